rv_alu_exec: RTL and testbench
==============================

# rv_alu_exec

Multi-cycle, parametrised integer execute unit for the RV32I/RV64I core datapath. Accepts one R-type (opcode 0110011) or I-type ALU (opcode 0010011) instruction over a valid/ready handshake. Decodes the instruction, reads an internal register bank and sign-extends the immediate. Executes the full base ALU op set (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and I-forms), then writes back. It replaces the add-only decode/regbank/ALU chain as the integer path between instruction memory and the later load/store/branch stages.

## Interface
- XLEN, 32: datapath width; legal values 32, 64.
- NREGS, 32: architectural registers; legal values 16 (E variant) or 32.
- SHW, $clog2(XLEN): shift-amount width (derived, not overridden).

- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- instr_valid  in  1  instr holds a valid instruction.
- instr_ready  out  1  unit can accept; high only in IDLE and rst low.
- instr  in  32  instruction word.
- wb_valid  out  1  one-cycle pulse; wb_* fields valid.
- wb_rd  out  5  destination index of retired instruction.
- wb_data  out  XLEN  ALU result (0 when illegal).
- wb_illegal  out  1  retired instruction was rejected, no write done.
- dbg_addr  in  5  debug read index.
- dbg_data  out  XLEN  combinational read of register dbg_addr (0 for x0 or index ≥ NREGS).

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE; no other transitions except reset.
- IDLE: instr_ready=1. On instr_valid&&instr_ready at an edge, the unit latches instr and goes to READ.
- READ: decodes fields. Latches rs1 and rs2 operands from the bank (x0 reads 0). Latches the 12-bit immediate, sign-extended to XLEN. Evaluates legality.
- EXEC: operand B = rs2 value for R-type, imm for I-type. Latches the result into wb_data register.
  - ADD/ADDI and SUB wrap modulo 2^XLEN.
  - SLT is signed; SLTU/SLTIU compares both operands as unsigned, with the immediate sign-extended first.
  - Shifts use B[SHW-1:0]. SRA/SRAI replicates the sign bit.
- WB: wb_valid=1. If legal and rd≠0, writes the bank at the edge leaving WB. x0 is never written.
- Illegal, all of which give wb_illegal=1, wb_data=0 and no bank write:
  - the opcode is neither of the two above;
  - an R-type funct7 other than 0000000, or 0100000 with funct3 other than 000/101;
  - an I-shift with instr[31:SHW] not 0 (SLLI/SRLI) or 0100000…0 (SRAI);
  - any rs1/rs2/rd index ≥ NREGS.
- Dependent back-to-back instructions need no forwarding: the write completes before the next READ.

## Timing
- Handshake at edge T. READ, EXEC and WB then occupy the cycles after edges T, T+1 and T+2.
- wb_valid is high in the cycle after T+2. The bank is updated at edge T+3.
- instr_ready returns high after T+3. Peak throughput is 1 instruction per 4 cycles.
- instr is ignored outside IDLE. instr_valid may stay high with no effect.
- Reset applies at the next edge with rst=1, from any state:
  - state → IDLE;
  - all registers → 0;
  - wb_valid=0, wb_rd=0, wb_data=0, wb_illegal=0;
  - instr_ready=0 while rst is high.
- Reset mid-operation aborts the instruction: no write and no wb_valid pulse.
- dbg_data reflects a write from the cycle after the write edge.

## Structure
- Package rv_pkg holds:
  - opcode constants OP_REG and OP_IMM;
  - funct3 enum (F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND);
  - funct7 constants F7_BASE and F7_ALT;
  - the alu_op_e enum;
  - the FSM state_e enum.
- Sub-module rv_regfile #(XLEN, NREGS) has two synchronous-write, combinational-read ports plus the debug read port. Its x0 is hardwired to 0.

## Test plan
- Reset, then ADDI x6,x28,3 (0x003E0313) → wb_valid 3 cycles after accept, wb_rd=6, wb_data=3, dbg x6=3.
- x5=5 (via ADDI), then SUB x7,x0,x5 → wb_data=0xFFFFFFFB. Then SRAI x8,x7,1 → 0xFFFFFFFD, and SRLI x9,x7,28 → 0xF.
- x7=−5: SLT x10,x7,x5 → 1. SLTU x11,x7,x5 → 0. SLTIU x12,x5,−1 → 1.
- ADDI x0,x0,7 → wb_valid with wb_data=7, but dbg x0 stays 0. Opcode 0000011 → wb_illegal=1 and no register changes.
- NREGS=16: ADD x20,x1,x2 → wb_illegal=1. XLEN=64: SLLI x1,x1,63 with x1=1 → 0x8000000000000000.
- rst pulsed during EXEC of ADDI x6,x0,9 → no wb_valid, x6=0, and instr_ready high the cycle after rst falls.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared opcode, funct and state definitions for the integer execute unit
package rv_pkg;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    typedef enum logic [2:0] {
        F3_ADD = 3'd0,
        F3_SLL = 3'd1,
        F3_SLT = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR = 3'd4,
        F3_SR = 3'd5,
        F3_OR = 3'd6,
        F3_AND = 3'd7
    } funct3_e;
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_e;
endpackage

// File: rtl/rv_regfile.sv
// rv_regfile: register bank, x0 hardwired to zero, two comb read ports + debug port, one sync write port
// ports: clk/rst, we/waddr/wdata write port, raddr_a/raddr_b -> rdata_a/rdata_b, dbg_addr -> dbg_data
module rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    output logic [XLEN-1:0] dbg_data
);
    localparam int AW = $clog2(NREGS);
    logic [XLEN-1:0] regs [NREGS];
    assign rdata_a = (raddr_a == 5'd0 || int'(raddr_a) >= NREGS) ? '0 : regs[raddr_a[AW-1:0]];
    assign rdata_b = (raddr_b == 5'd0 || int'(raddr_b) >= NREGS) ? '0 : regs[raddr_b[AW-1:0]];
    assign dbg_data = (dbg_addr == 5'd0 || int'(dbg_addr) >= NREGS) ? '0 : regs[dbg_addr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0 && int'(waddr) < NREGS) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/rv_alu_exec.sv
// rv_alu_exec: multi-cycle RV32I/RV64I R-type and I-type ALU execute unit with internal register bank
// ports: clk/rst; instr_valid/instr_ready/instr accept one instruction in IDLE;
// wb_valid/wb_rd/wb_data/wb_illegal report the retired instruction; dbg_addr -> dbg_data reads the bank
module rv_alu_exec
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int SHW = $clog2(XLEN);
    state_e state, state_n;
    logic [31:0] instr_q, shift_hi;
    logic [6:0] opc, f7;
    logic [4:0] rd, rs1, rs2;
    funct3_e f3;
    logic is_reg, is_imm, is_imm_q, legal_d, legal_q;
    alu_op_e op_d, op_q;
    logic [XLEN-1:0] rs1_v, rs2_v, rs1_q, rs2_q, imm_q, op_b, sra_r, res;
    logic [SHW-1:0] shamt;
    assign opc = instr_q[6:0];
    assign rd = instr_q[11:7];
    assign f3 = funct3_e'(instr_q[14:12]);
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign f7 = instr_q[31:25];
    assign is_reg = opc == OP_REG;
    assign is_imm = opc == OP_IMM;
    assign shift_hi = instr_q >> (20 + SHW);
    assign legal_d = (is_reg ? (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)))
                    : is_imm ? (f3 == F3_SLL ? shift_hi == 32'd0
                               : f3 == F3_SR ? (shift_hi == 32'd0 || shift_hi == (32'd1 << (10 - SHW)))
                               : 1'b1)
                    : 1'b0)
                  && int'(rd) < NREGS && int'(rs1) < NREGS && (!is_reg || int'(rs2) < NREGS);
    assign op_d = f3 == F3_ADD ? ((is_reg && instr_q[30]) ? ALU_SUB : ALU_ADD)
                : f3 == F3_SLL ? ALU_SLL
                : f3 == F3_SLT ? ALU_SLT
                : f3 == F3_SLTU ? ALU_SLTU
                : f3 == F3_XOR ? ALU_XOR
                : f3 == F3_SR ? (instr_q[30] ? ALU_SRA : ALU_SRL)
                : f3 == F3_OR ? ALU_OR
                : ALU_AND;
    assign op_b = is_imm_q ? imm_q : rs2_q;
    assign shamt = op_b[SHW-1:0];
    assign sra_r = $signed(rs1_q) >>> shamt;
    always_comb begin
        res = op_q == ALU_ADD ? rs1_q + op_b
            : op_q == ALU_SUB ? rs1_q - op_b
            : op_q == ALU_SLL ? rs1_q << shamt
            : op_q == ALU_SLT ? XLEN'($signed(rs1_q) < $signed(op_b))
            : op_q == ALU_SLTU ? XLEN'(rs1_q < op_b)
            : op_q == ALU_XOR ? rs1_q ^ op_b
            : op_q == ALU_SRL ? rs1_q >> shamt
            : op_q == ALU_SRA ? sra_r
            : op_q == ALU_OR ? rs1_q | op_b
            : rs1_q & op_b;
    end
    always_comb begin
        state_n = state == S_IDLE ? (instr_valid ? S_READ : S_IDLE)
                : state == S_READ ? S_EXEC
                : state == S_EXEC ? S_WB
                : S_IDLE;
    end
    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_n;
    end
    assign instr_ready = state == S_IDLE && !rst;
    assign wb_valid = state == S_WB;
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            is_imm_q <= 1'b0;
            legal_q <= 1'b0;
            op_q <= ALU_ADD;
            wb_rd <= '0;
            wb_data <= '0;
            wb_illegal <= 1'b0;
        end else begin
            if (instr_valid && instr_ready) instr_q <= instr;
            if (state == S_READ) begin
                rs1_q <= rs1_v;
                rs2_q <= rs2_v;
                imm_q <= {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                is_imm_q <= is_imm;
                legal_q <= legal_d;
                op_q <= op_d;
            end
            if (state == S_EXEC) begin
                wb_rd <= rd;
                wb_data <= legal_q ? res : '0;
                wb_illegal <= !legal_q;
            end
        end
    end
    rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk(clk),
        .rst(rst),
        .we(state == S_WB && !wb_illegal && wb_rd != 5'd0),
        .waddr(wb_rd),
        .wdata(wb_data),
        .raddr_a(rs1),
        .raddr_b(rs2),
        .dbg_addr(dbg_addr),
        .rdata_a(rs1_v),
        .rdata_b(rs2_v),
        .dbg_data(dbg_data)
    );
endmodule

// File: tb/tb_rv_alu_exec.sv
// tb_rv_alu_exec: three configurations (32/32, 64/32, 32/16) driven in lockstep against a behavioural model
module tb_rv_alu_exec;
    logic clk = 0, rst = 1, instr_valid = 0;
    logic [31:0] instr = 0;
    logic [4:0] dbg_addr = 0;
    always #5 clk = ~clk;
    logic rdy32, rdy64, rdy16, wbv32, wbv64, wbv16, il32, il64, il16;
    logic [4:0] rd32, rd64, rd16;
    logic [31:0] d32, d16, g32, g16;
    logic [63:0] d64, g64;
    rv_alu_exec #(.XLEN(32), .NREGS(32)) dut32 (.clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy32),
        .instr(instr), .wb_valid(wbv32), .wb_rd(rd32), .wb_data(d32), .wb_illegal(il32), .dbg_addr(dbg_addr), .dbg_data(g32));
    rv_alu_exec #(.XLEN(64), .NREGS(32)) dut64 (.clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy64),
        .instr(instr), .wb_valid(wbv64), .wb_rd(rd64), .wb_data(d64), .wb_illegal(il64), .dbg_addr(dbg_addr), .dbg_data(g64));
    rv_alu_exec #(.XLEN(32), .NREGS(16)) dut16 (.clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(rdy16),
        .instr(instr), .wb_valid(wbv16), .wb_rd(rd16), .wb_data(d16), .wb_illegal(il16), .dbg_addr(dbg_addr), .dbg_data(g16));
    logic rdy [3], wbv [3], ill [3];
    logic [4:0] wrd [3];
    logic [63:0] dat [3], dbg [3];
    assign rdy[0] = rdy32; assign rdy[1] = rdy64; assign rdy[2] = rdy16;
    assign wbv[0] = wbv32; assign wbv[1] = wbv64; assign wbv[2] = wbv16;
    assign ill[0] = il32;  assign ill[1] = il64;  assign ill[2] = il16;
    assign wrd[0] = rd32;  assign wrd[1] = rd64;  assign wrd[2] = rd16;
    assign dat[0] = 64'(d32); assign dat[1] = d64; assign dat[2] = 64'(d16);
    assign dbg[0] = 64'(g32); assign dbg[1] = g64; assign dbg[2] = 64'(g16);
    int checks = 0, failures = 0;
    bit go = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask
    function automatic logic [64:0] ref_exec(input logic [31:0] i, input int w, input int n,
                                             input logic [63:0] a, input logic [63:0] r2);
        logic [63:0] mask, b, d;
        logic signed [63:0] sa, sb;
        logic [6:0] hi;
        logic is_r, is_i, bad, alt;
        int sh;
        mask = w == 64 ? '1 : 64'hFFFF_FFFF;
        is_r = i[6:0] == 7'h33;
        is_i = i[6:0] == 7'h13;
        b = is_r ? r2 : ({{52{i[31]}}, i[31:20]} & mask);
        sa = w == 64 ? a : {{32{a[31]}}, a[31:0]};
        sb = w == 64 ? b : {{32{b[31]}}, b[31:0]};
        sh = w == 64 ? int'(b[5:0]) : int'(b[4:0]);
        hi = w == 64 ? {1'b0, i[31:26]} : i[31:25];
        bad = !(is_r || is_i) || int'(i[11:7]) >= n || int'(i[19:15]) >= n || (is_r && int'(i[24:20]) >= n);
        if (is_r && i[31:25] != 0 && !(i[31:25] == 7'h20 && (i[14:12] == 0 || i[14:12] == 5))) bad = 1;
        if (is_i && i[14:12] == 1 && hi != 0) bad = 1;
        if (is_i && i[14:12] == 5 && hi != 0 && hi != (w == 64 ? 7'h10 : 7'h20)) bad = 1;
        alt = is_r ? i[30] : (i[14:12] == 5 && i[30]);
        d = 0;
        case (i[14:12])
            3'd0: d = alt ? a - b : a + b;
            3'd1: d = a << sh;
            3'd2: d = {63'b0, sa < sb};
            3'd3: d = {63'b0, a < b};
            3'd4: d = a ^ b;
            3'd5: if (alt) d = sa >>> sh; else d = a >> sh;
            3'd6: d = a | b;
            default: d = a & b;
        endcase
        return bad ? 65'h1_0000_0000_0000_0000 : {1'b0, d & mask};
    endfunction
    int cnt = 0;
    int w_c [3] = '{32, 64, 32};
    int n_c [3] = '{32, 32, 16};
    logic [63:0] m [3][32];
    logic [64:0] e_res [3];
    logic [4:0] e_rd = 0;
    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0;
            for (int c = 0; c < 3; c++) for (int r = 0; r < 32; r++) m[c][r] <= 0;
        end else if (cnt == 0) begin
            if (instr_valid) begin
                cnt <= 1;
                e_rd <= instr[11:7];
                for (int c = 0; c < 3; c++)
                    e_res[c] <= ref_exec(instr, w_c[c], n_c[c], m[c][instr[19:15]], m[c][instr[24:20]]);
            end
        end else if (cnt == 3) begin
            cnt <= 0;
            for (int c = 0; c < 3; c++) if (!e_res[c][64] && e_rd != 0) m[c][e_rd] <= e_res[c][63:0];
        end else begin
            cnt <= cnt + 1;
        end
    end
    always @(negedge clk) begin
        if (go) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("cfg%0d_ready", c), 64'(rdy[c]), 64'(cnt == 0 && !rst));
                chk($sformatf("cfg%0d_wb_valid", c), 64'(wbv[c]), 64'(cnt == 3));
                if (cnt == 3) begin
                    chk($sformatf("cfg%0d_wb_rd", c), 64'(wrd[c]), 64'(e_rd));
                    chk($sformatf("cfg%0d_wb_data", c), dat[c], e_res[c][63:0]);
                    chk($sformatf("cfg%0d_wb_illegal", c), 64'(ill[c]), 64'(e_res[c][64]));
                end
                chk($sformatf("cfg%0d_dbg_x%0d", c, dbg_addr), dbg[c], m[c][dbg_addr]);
            end
        end
    end
    logic s_wbv, s_il32, s_il64, s_il16;
    logic [4:0] s_rd;
    logic [63:0] s_d32, s_d64;
    task automatic issue(input logic [31:0] ins);
        int k;
        k = 0;
        @(posedge clk); #1;
        instr = ins;
        instr_valid = 1;
        while (!rdy32 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_within_bound", 64'(k < 8), 64'(1));
        @(posedge clk); #1;
        instr_valid = 0;
        instr = $urandom;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        s_wbv = wbv32; s_rd = rd32; s_d32 = 64'(d32); s_il32 = il32;
        s_d64 = d64; s_il64 = il64; s_il16 = il16;
        @(posedge clk); #1;
    endtask
    task automatic dbg_chk(input string nm, input logic [4:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1;
        chk(nm, 64'(g32), exp);
    endtask
    function automatic logic [4:0] pick_idx();
        return ($urandom % 5 == 0) ? 5'($urandom) : 5'($urandom % 16);
    endfunction
    function automatic logic [31:0] gen();
        logic [6:0] opc, f7;
        int k;
        k = $urandom % 10;
        opc = k == 0 ? 7'($urandom) : (k < 5 ? 7'h33 : 7'h13);
        k = $urandom % 10;
        f7 = k < 5 ? 7'h00 : (k < 8 ? 7'h20 : 7'($urandom));
        return {f7, pick_idx(), pick_idx(), 3'($urandom), pick_idx(), opc};
    endfunction
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        go = 1;
        @(negedge clk);
        chk("rst_wb_valid", 64'(wbv32), 0);
        chk("rst_wb_data", 64'(d32), 0);
        chk("rst_wb_rd", 64'(rd32), 0);
        chk("rst_wb_illegal", 64'(il32), 0);
        chk("rst_ready", 64'(rdy32), 1);
        issue(32'h003E0313);
        chk("addi_wb_valid", 64'(s_wbv), 1);
        chk("addi_wb_rd", 64'(s_rd), 6);
        chk("addi_wb_data", s_d32, 3);
        dbg_chk("addi_dbg_x6", 5'd6, 3);
        issue(32'h00500293);
        issue(32'h405003B3);
        chk("sub_data", s_d32, 64'hFFFF_FFFB);
        chk("sub_data64", s_d64, 64'hFFFF_FFFF_FFFF_FFFB);
        issue(32'h4013D413);
        chk("srai_data", s_d32, 64'hFFFF_FFFD);
        issue(32'h01C3D493);
        chk("srli_data", s_d32, 64'hF);
        issue(32'h0053A533);
        chk("slt_data", s_d32, 1);
        issue(32'h0053B5B3);
        chk("sltu_data", s_d32, 0);
        issue(32'hFFF2B613);
        chk("sltiu_data", s_d32, 1);
        issue(32'h00700013);
        chk("addi_x0_data", s_d32, 7);
        chk("addi_x0_wb_valid", 64'(s_wbv), 1);
        dbg_chk("x0_stays_zero", 5'd0, 0);
        issue(32'h00002303);
        chk("bad_opcode_illegal", 64'(s_il32), 1);
        chk("bad_opcode_data", s_d32, 0);
        dbg_chk("bad_opcode_x6_kept", 5'd6, 3);
        issue(32'h00208A33);
        chk("nregs16_illegal", 64'(s_il16), 1);
        chk("nregs32_legal", 64'(s_il32), 0);
        issue(32'h00100093);
        issue(32'h03F09093);
        chk("slli63_xlen64", s_d64, 64'h8000_0000_0000_0000);
        chk("slli63_xlen64_legal", 64'(s_il64), 0);
        chk("slli63_xlen32_illegal", 64'(s_il32), 1);
        instr = 32'h00900313;
        instr_valid = 1;
        chk("abort_pre_ready", 64'(rdy32), 1);
        @(posedge clk); #1;
        instr_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("abort_ready_in_rst", 64'(rdy32), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_no_wb_valid", 64'(wbv32), 0);
        chk("abort_ready_after", 64'(rdy32), 1);
        @(negedge clk);
        chk("abort_no_wb_valid_late", 64'(wbv32), 0);
        dbg_chk("abort_x6_zero", 5'd6, 0);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom % 80) == 0;
            instr_valid = ($urandom % 4) != 0;
            instr = gen();
            dbg_addr = 5'($urandom);
        end
        @(posedge clk); #1;
        rst = 0;
        instr_valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
